alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes the unsigned 8-bit product of two operands using only the ALU's ADD operation and shift-and-add sequencing. It sits beside the ALU and owns the ALU's DATA1/DATA2/SELECT inputs while busy. It returns the low 8 bits of the product plus an overflow flag through a START/BUSY/DONE handshake. The CPU datapath uses it for a MUL instruction by stalling until DONE.

---
 rtl/alu_mul_sequencer_pkg.sv | 19 +
 rtl/alu_mul_sequencer.sv | 105 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer:
// ALU opcodes and the controller state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [2:0] ALUOP_FORWARD = 3'b000;
  localparam logic [2:0] ALUOP_ADD     = 3'b001;
  localparam logic [2:0] ALUOP_AND     = 3'b010;
  localparam logic [2:0] ALUOP_OR      = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_ADD,
    ST_WB,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned 8x8 multiplier (low 8 bits + overflow) that borrows
// the external ALU for every addition. It walks the multiplier LSB first,
// adding the shifted multiplicand for each set bit, and stops as soon as
// no set multiplier bits remain.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic [7:0] alu_result,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       overflow
);

  state_t     state;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [7:0] acc;
  logic       ovf;
  logic       lost;

  // Controller: state, datapath registers and all registered outputs.
  // The ALU drive is set on entry to ADD and held through WB, so the ALU
  // sees stable operands for a full cycle before its result is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mcand      <= 8'd0;
      mplier     <= 8'd0;
      acc        <= 8'd0;
      ovf        <= 1'b0;
      lost       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      alu_data1  <= 8'd0;
      alu_data2  <= 8'd0;
      alu_select <= ALUOP_FORWARD;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand    <= operand_a;
            mplier   <= operand_b;
            acc      <= 8'd0;
            ovf      <= 1'b0;
            lost     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_EVAL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          if (mplier == 8'd0) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= ovf;
            state    <= ST_DONE;
          end else if (mplier[0]) begin
            alu_data1  <= acc;
            alu_data2  <= mcand;
            alu_select <= ALUOP_ADD;
            state      <= ST_ADD;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_ADD: begin
          state <= ST_WB;
        end
        ST_WB: begin
          acc        <= alu_result;
          ovf        <= ovf | (alu_result < acc) | lost;
          alu_data1  <= 8'd0;
          alu_data2  <= 8'd0;
          alu_select <= ALUOP_FORWARD;
          state      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          mcand  <= mcand << 1;
          lost   <= lost | mcand[7];
          mplier <= mplier >> 1;
          state  <= ST_EVAL;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU sits beside the sequencer,
// every accepted multiply pushes its expected result onto a scoreboard, and
// a monitor pops and compares each time DONE pulses.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] alu_result;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [2:0] alu_select;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       overflow;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] product;
    logic       ovf;
    int         cycles;
    int         startEdge;
  } job_t;

  job_t sb[$];
  job_t monJob;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busyCnt = 0;
  int   addCnt = 0;

  alu_mul_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_result (alu_result),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_select (alu_select),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .overflow   (overflow)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Edge counter used to time each job from its accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational stand-in for the existing ALU.
  always_comb begin
    alu_result = 8'd0;
    case (alu_select)
      ALUOP_FORWARD: alu_result = alu_data2;
      ALUOP_ADD:     alu_result = alu_data1 + alu_data2;
      ALUOP_AND:     alu_result = alu_data1 & alu_data2;
      ALUOP_OR:      alu_result = alu_data1 | alu_data2;
      default:       alu_result = 8'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Cycle in which DONE should appear, counting the EVAL after START as 1.
  function automatic int expCycles(input logic [7:0] b);
    int n = 0;
    int k = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        n = i + 1;
        k++;
      end
    end
    return 2 * n + 2 * k + 2;
  endfunction

  // Drive START for one cycle from the current falling edge and log the
  // expected outcome. Returns at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    job_t       j;
    logic [15:0] full;
    full        = 16'(a) * 16'(b);
    j.a         = a;
    j.b         = b;
    j.product   = full[7:0];
    j.ovf       = (full > 16'd255);
    j.cycles    = expCycles(b);
    j.startEdge = cyc + 1;
    sb.push_back(j);
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for DONE, sampling on falling edges.
  task automatic waitDone();
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    checkOutput("done_timeout", int'(done), 1);
  endtask

  // One complete job followed by an idle cycle in which results must hold.
  task automatic runJob(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] full;
    full = 16'(a) * 16'(b);
    applyStimulus(a, b);
    waitDone();
    @(negedge clk);
    checkOutput("idle_done", int'(done), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("held_product", int'(product), int'(full[7:0]));
    checkOutput("held_overflow", int'(overflow), int'(full > 16'd255));
  endtask

  // Scoreboard monitor: tracks busy and ALU-add cycles of the job in flight
  // and compares everything when DONE pulses.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      sb.delete();
      busyCnt = 0;
      addCnt  = 0;
    end else if (sb.size() > 0 && cyc >= sb[0].startEdge) begin
      if (busy === 1'b1) busyCnt++;
      if (alu_select === ALUOP_ADD) addCnt++;
      if (done === 1'b1) begin
        monJob = sb.pop_front();
        checkOutput("product", int'(product), int'(monJob.product));
        checkOutput("overflow", int'(overflow), int'(monJob.ovf));
        checkOutput("done_cycle", cyc - monJob.startEdge + 1, monJob.cycles);
        checkOutput("busy_cycles", busyCnt, monJob.cycles - 1);
        checkOutput("add_cycles", addCnt, 2 * $countones(monJob.b));
        busyCnt = 0;
        addCnt  = 0;
      end
    end else if (done === 1'b1) begin
      checkOutput("unexpected_done", int'(done), 0);
    end
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operand_a = 8'd0;
    operand_b = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_product", int'(product), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_data1", int'(alu_data1), 0);
    checkOutput("rst_data2", int'(alu_data2), 0);
    checkOutput("rst_select", int'(alu_select), int'(ALUOP_FORWARD));

    $display("[TB] directed multiplies");
    runJob(8'd6, 8'd7);
    runJob(8'd100, 8'd3);
    runJob(8'h10, 8'h10);
    runJob(8'd15, 8'd17);
    runJob(8'd5, 8'd0);
    runJob(8'd255, 8'd255);

    $display("[TB] START while busy, then back-to-back");
    applyStimulus(8'd3, 8'd4);
    @(negedge clk);
    operand_a = 8'd9;
    operand_b = 8'd9;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    applyStimulus(8'd9, 8'd9);
    checkOutput("b2b_busy", int'(busy), 1);
    waitDone();
    @(negedge clk);

    $display("[TB] reset in WB");
    applyStimulus(8'd200, 8'd200);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_product", int'(product), 0);
    checkOutput("abort_overflow", int'(overflow), 0);
    checkOutput("abort_data1", int'(alu_data1), 0);
    checkOutput("abort_data2", int'(alu_data2), 0);
    checkOutput("abort_select", int'(alu_select), int'(ALUOP_FORWARD));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", int'(done), 0);
    runJob(8'd2, 8'd3);

    $display("[TB] random multiplies");
    for (int i = 0; i < 4; i++) begin
      runJob(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    checkOutput("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
